// File: rtl/fifo32x2_ctrl.sv
// fifo32x2_ctrl: 33-entry 2-bit FIFO controller around a 32x2 single-port async-read RAM with FWFT prefetch.
module fifo32x2_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_data,
  input  logic       out_ready,
  output logic [4:0] ram_addr,
  output logic [1:0] ram_d,
  output logic       ram_we,
  input  logic [1:0] ram_o,
  output logic [5:0] level,
  output logic       full,
  output logic       empty
);
  logic [4:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [5:0] ram_count_q, ram_count_d;
  logic       prio_q, prio_d, out_valid_q, out_valid_d;
  logic [1:0] out_data_q, out_data_d;
  logic       want_wr, want_fill, grant_wr, grant_fill;
  always_comb begin
    want_wr     = in_valid && (ram_count_q != 6'd32);
    want_fill   = (ram_count_q != 6'd0) && (!out_valid_q || out_ready);
    // On contention prio picks the winner and then flips, so neither side starves
    grant_wr    = want_wr && !(want_fill && prio_q);
    grant_fill  = want_fill && !(want_wr && !prio_q);
    prio_d      = (want_wr && want_fill) ? !prio_q : prio_q;
    wr_ptr_d    = grant_wr ? wr_ptr_q + 5'd1 : wr_ptr_q;
    rd_ptr_d    = grant_fill ? rd_ptr_q + 5'd1 : rd_ptr_q;
    ram_count_d = grant_wr ? ram_count_q + 6'd1 : grant_fill ? ram_count_q - 6'd1 : ram_count_q;
    out_data_d  = grant_fill ? ram_o : out_data_q;
    out_valid_d = grant_fill ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign ram_addr  = grant_wr ? wr_ptr_q : rd_ptr_q;
  assign ram_d     = in_data;
  assign ram_we    = grant_wr && !reset;
  assign in_ready  = grant_wr && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = ram_count_q + {5'd0, out_valid_q};
  assign full      = ram_count_q == 6'd32;
  assign empty     = level == 6'd0;
endmodule

// File: tb/tb_fifo32x2_ctrl.sv
// tb_fifo32x2_ctrl: directed table, corner sequences and random traffic against a queue-based FIFO model.
module tb_fifo32x2_ctrl;
  logic       clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [1:0] in_data = 0;
  logic       in_ready, out_valid, ram_we, full, empty;
  logic [1:0] out_data, ram_d, ram_o;
  logic [4:0] ram_addr;
  logic [5:0] level;
  logic [1:0] mem [32];

  fifo32x2_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_we(ram_we), .ram_o(ram_o), .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
  assign ram_o = mem[ram_addr];

  logic [1:0] mq[$];
  bit         mov, mprio, last_ir;
  logic [1:0] mod;
  int         nw, nr, pops, ir_cnt, nchk, nerr;

  task automatic chk(input string n, input int a, input int e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // One clock cycle: check combinational port drive, advance the model, check registered outputs.
  task automatic step();
    bit ww, wf, gw, gf;
    #1;
    ww = in_valid && mq.size() < 32;
    wf = mq.size() > 0 && (!mov || out_ready);
    gw = ww && !(wf && mprio);
    gf = wf && !(ww && !mprio);
    last_ir = in_ready;
    if (in_ready) ir_cnt++;
    chk("in_ready", in_ready, gw && !reset);
    chk("ram_we", ram_we, gw && !reset);
    chk("ram_addr", ram_addr, gw ? nw % 32 : nr % 32);
    chk("ram_d", ram_d, in_data);
    @(posedge clk);
    if (reset) begin
      mq.delete(); mov = 0; mod = 0; mprio = 0; nw = 0; nr = 0;
    end else begin
      if (ww && wf) mprio = !mprio;
      if (mov && out_ready) pops++;
      if (gf) begin mod = mq.pop_front(); mov = 1; nr++; end
      else if (mov && out_ready) mov = 0;
      if (gw) begin mq.push_back(in_data); nw++; end
    end
    #1;
    chk("out_valid", out_valid, mov);
    chk("out_data", out_data, mod);
    chk("level", level, mq.size() + mov);
    chk("full", full, mq.size() == 32);
    chk("empty", empty, mq.size() + mov == 0);
  endtask

  typedef struct {
    bit iv; bit [1:0] d; bit ordy;
    bit eir; bit eov; bit [1:0] eod; int elvl;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int k;
    tbl[0] = '{1, 0, 0, 1, 0, 0, 1};
    tbl[1] = '{0, 0, 0, 0, 1, 0, 1};
    tbl[2] = '{1, 1, 0, 1, 1, 0, 2};
    tbl[3] = '{1, 2, 0, 1, 1, 0, 3};
    tbl[4] = '{1, 3, 0, 1, 1, 0, 4};
    tbl[5] = '{0, 0, 1, 0, 1, 1, 3};
    tbl[6] = '{0, 0, 1, 0, 1, 2, 2};
    tbl[7] = '{0, 0, 1, 0, 1, 3, 1};
    tbl[8] = '{0, 0, 1, 0, 0, 3, 0};
    @(posedge clk); #1;
    in_valid = 1;
    step();
    chk("reset_in_ready", last_ir, 0);
    chk("reset_level", level, 0);
    chk("reset_full", full, 0);
    chk("reset_empty", empty, 1);
    reset = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      step();
      chk("tbl_in_ready", last_ir, tbl[i].eir);
      chk("tbl_out_valid", out_valid, tbl[i].eov);
      chk("tbl_out_data", out_data, tbl[i].eod);
      chk("tbl_level", level, tbl[i].elvl);
    end
    // Fill to capacity, then drain in order
    in_valid = 1; out_ready = 0; k = 0;
    for (int i = 0; i < 80 && level != 33; i++) begin
      in_data = 2'(k); step();
      if (last_ir) k++;
    end
    chk("fill_level", level, 33);
    chk("fill_full", full, 1);
    step();
    chk("full_in_ready", last_ir, 0);
    in_valid = 0; out_ready = 1; k = 0;
    for (int i = 0; i < 80 && !empty; i++) begin
      if (out_valid) begin chk("drain_order", out_data, k % 4); k++; end
      step();
    end
    if (out_valid) k++;
    chk("drain_count", k, 33);
    chk("drain_empty", empty, 1);
    // Sustained contention from empty: alternating grants
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin in_data = 2'($urandom); step(); end
    ir_cnt = 0; pops = 0;
    for (int i = 0; i < 20; i++) begin in_data = 2'($urandom); step(); end
    chk("contend_writes", ir_cnt, 10);
    chk("contend_pops", pops, 10);
    // Random traffic through several pointer wraps
    pops = 0;
    for (int i = 0; i < 3000 && pops < 100; i++) begin
      in_valid = $urandom_range(0, 3) != 0; out_ready = $urandom_range(0, 2) != 0;
      in_data = 2'($urandom); step();
    end
    chk("random_done", pops >= 100, 1);
    chk("random_wraps", nw >= 100, 1);
    // Reset mid-stream at level 10
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 80 && !empty; i++) step();
    in_valid = 1; out_ready = 0; in_data = 2'd1;
    for (int i = 0; i < 40 && level != 10; i++) step();
    chk("pre_reset_level", level, 10);
    reset = 1;
    step();
    chk("mid_reset_we", last_ir, 0);
    chk("mid_reset_level", level, 0);
    chk("mid_reset_out_valid", out_valid, 0);
    reset = 0; in_data = 2'd3;
    step();
    in_valid = 0;
    step();
    chk("post_reset_out_valid", out_valid, 1);
    chk("post_reset_out_data", out_data, 3);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
